alu_stream: RTL and testbench
=============================

ALU_STREAM -- requirements
Module: alu_stream

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 2..32.
REQ-002 Parameter CNT_W, default 16: width of the completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a_in, b_in  input  WIDTH each  unsigned operands.
REQ-008 mode_in  input  4  operation select.
REQ-009 out_valid  output  1  result held on c_out/err_out.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 c_out  output  WIDTH  result.
REQ-012 err_out  output  1  result came from an illegal mode.
REQ-013 op_count  output  CNT_W  number of results consumed.

Function
REQ-014 Input transfer occurs on an edge where in_valid && in_ready; output transfer occurs on an edge where out_valid && out_ready.
REQ-015 Modes: 0 a+b; 1 a-b; 2 b-a; 3 a*b (low WIDTH bits); 4 a>>b; 5 a<<b; 6 b>>a; 7 b<<a; 8 a^b; 9 a&b; 10 a|b; 11..15 illegal.
REQ-016 Shift amounts >= WIDTH yield 0; shifts are logical.
REQ-017 Illegal mode: c_out=0, err_out=1, single-cycle latency; legal modes set err_out=0.
REQ-018 FSM states IDLE and MUL; reset state IDLE.
REQ-019 in_ready = (state==IDLE) && (!out_valid || out_ready) && !rst; combinational, no dependence on in_valid.
REQ-020 Non-multiply op accepted at edge k: out_valid=1 with result from edge k, stays in IDLE.
REQ-021 Multiply accepted at edge k: IDLE->MUL; shift-add, one multiplier bit per cycle; out_valid=1 from edge k+WIDTH; MUL->IDLE on that edge.
REQ-022 in_ready=0 throughout MUL; inputs ignored.
REQ-023 Operands are captured at acceptance; a_in/b_in/mode_in changes afterwards do not affect the result.
REQ-024 c_out/err_out are held stable while out_valid && !out_ready.
REQ-025 out_valid clears on output transfer unless a new single-cycle result is loaded on the same edge (back-to-back: one result per cycle).
REQ-026 op_count increments by 1 per output transfer, wraps from 2^CNT_W-1 to 0.
REQ-027 At most one operation in flight; no result is lost or duplicated.

Reset
REQ-028 While rst=1 at an edge: state=IDLE, out_valid=0, c_out=0, err_out=0, op_count=0, multiply datapath cleared.
REQ-029 rst asserted mid-multiply aborts it; no result is produced.
REQ-030 in_ready=0 in any cycle where rst=1.
REQ-031 First transfer possible on the first edge after rst deasserts.

Configuration
REQ-032 Macro ALU_STREAM_SAT_EN defined: modes 0 and 3 saturate to 2^WIDTH-1 on overflow; modes 1 and 2 clamp to 0 on underflow.
REQ-033 Macro ALU_STREAM_SAT_EN undefined: modes 0-3 wrap modulo 2^WIDTH; all other modes are identical in both builds.

Verification (WIDTH=8)
REQ-034 Modes 0,1,2,4,5,6,7 with (12,34),(45,10),(10,44),(9,1),(9,1),(2,32),(3,3) -> c_out 46,35,34,4,18,8,24, 1-cycle latency, err_out=0.
REQ-035 Mode 3, (3,7) -> c_out=21 exactly 8 cycles after acceptance; in_ready=0 for those cycles.
REQ-036 Mode 0 (200,100) -> 44 without macro, 255 with; mode 1 (10,20) -> 246 without, 0 with.
REQ-037 Mode 12, (1,1) -> c_out=0, err_out=1; mode 9 (56,78) next -> c_out=8, err_out=0.
REQ-038 out_ready held 0 for 5 cycles after a result -> c_out stable, in_ready=0, op_count unchanged; then out_ready=1 with in_valid continuously 1 -> one transfer per edge, op_count increments each edge.
REQ-039 rst pulsed 3 cycles into a mode-3 operation -> no out_valid, op_count=0, next op completes normally.

Source files
------------

// File: rtl/alu_stream.sv
// alu_stream: streaming ALU with a valid/ready handshake on each side.
// Most modes finish in one cycle. Multiply (mode 3) is a shift-add over
// WIDTH cycles. Holds a wrapping count of results taken by the consumer.
// Optional build macro: ALU_STREAM_SAT_EN. When defined, add and multiply
// saturate and the two subtract modes clamp at zero. When undefined, those
// modes wrap.
module alu_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       mode_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c_out,
    output logic             err_out,
    output logic [CNT_W-1:0] op_count
);

    // The step counter only has to count 0..WIDTH-1.
    localparam int SW = $clog2(WIDTH);
`ifdef ALU_STREAM_SAT_EN
    // Keep the full double-width product so the overflow can be detected.
    localparam int PW = 2 * WIDTH;
`else
    localparam int PW = WIDTH;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  c_q, c_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [SW-1:0]     step_q, step_d;

    logic [WIDTH-1:0]  addRes, subAbRes, subBaRes, mulRes;
    logic [PW-1:0]     prodNext;
    logic [WIDTH-1:0]  aluRes;
    logic              aluErr;

`ifdef ALU_STREAM_SAT_EN
    logic [WIDTH:0] addWide, subAbWide, subBaWide;
    assign addWide   = {1'b0, a_in} + {1'b0, b_in};
    assign subAbWide = {1'b0, a_in} - {1'b0, b_in};
    assign subBaWide = {1'b0, b_in} - {1'b0, a_in};
    assign addRes    = addWide[WIDTH]   ? '1 : addWide[WIDTH-1:0];
    assign subAbRes  = subAbWide[WIDTH] ? '0 : subAbWide[WIDTH-1:0];
    assign subBaRes  = subBaWide[WIDTH] ? '0 : subBaWide[WIDTH-1:0];
`else
    assign addRes    = a_in + b_in;
    assign subAbRes  = a_in - b_in;
    assign subBaRes  = b_in - a_in;
`endif

    // The partial product after this cycle's multiplier bit.
    assign prodNext = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef ALU_STREAM_SAT_EN
    assign mulRes = (|prodNext[PW-1:WIDTH]) ? '1 : prodNext[WIDTH-1:0];
`else
    assign mulRes = prodNext;
`endif

    // Operands are taken only when idle and when any held result is leaving.
    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready) && !rst;
    assign out_valid = out_valid_q;
    assign c_out     = c_q;
    assign err_out   = err_q;
    assign op_count  = cnt_q;

    // Single-cycle result for the mode on the inputs. Logical shifts by
    // WIDTH or more already give zero, so no special case is needed.
    always_comb begin
        aluRes = '0;
        aluErr = 1'b0;
        case (mode_in)
            4'd0:    aluRes = addRes;
            4'd1:    aluRes = subAbRes;
            4'd2:    aluRes = subBaRes;
            4'd4:    aluRes = a_in >> b_in;
            4'd5:    aluRes = a_in << b_in;
            4'd6:    aluRes = b_in >> a_in;
            4'd7:    aluRes = b_in << a_in;
            4'd8:    aluRes = a_in ^ b_in;
            4'd9:    aluRes = a_in & b_in;
            4'd10:   aluRes = a_in | b_in;
            4'd3:    aluRes = '0;
            default: aluErr = 1'b1;
        endcase
    end

    // Next state: output handshake, operand acceptance and multiply steps.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        c_d         = c_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        step_d      = step_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            cnt_d       = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (mode_in == 4'd3) begin
                        state_d  = MUL;
                        mcand_d  = PW'(a_in);
                        mplier_d = b_in;
                        acc_d    = '0;
                        step_d   = '0;
                    end else begin
                        out_valid_d = 1'b1;
                        c_d         = aluRes;
                        err_d       = aluErr;
                    end
                end
            end
            MUL: begin
                acc_d    = prodNext;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                step_d   = step_q + 1'b1;
                if (step_q == SW'(WIDTH - 1)) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    c_d         = mulRes;
                    err_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. Reset drops any multiply in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            step_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
        end
    end

endmodule

// File: tb/tb_alu_stream.sv
// tb_alu_stream: self-checking bench for alu_stream at WIDTH=8.
// Expected values come from an arithmetic reference model. The model follows
// ALU_STREAM_SAT_EN in the same way as the design.
module tb_alu_stream;

    localparam int W = 8;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic [3:0]    mode_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  c_out;
    logic          err_out;
    logic [CW-1:0] op_count;

    int checks = 0;
    int errors = 0;
    int expCount = 0;

    alu_stream #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a_in(a_in),
        .b_in(b_in),
        .mode_in(mode_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .c_out(c_out),
        .err_out(err_out),
        .op_count(op_count)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. The result is {err, c}.
    function automatic logic [W:0] model(input longint a, input longint b, input int m);
        longint r;
        longint maxv;
        maxv = (longint'(1) << W) - 1;
        r = 0;
        case (m)
            0: r = a + b;
            1: r = a - b;
            2: r = b - a;
            3: r = a * b;
            4: r = (b >= W) ? 0 : (a >> b);
            5: r = (b >= W) ? 0 : (a << b);
            6: r = (a >= W) ? 0 : (b >> a);
            7: r = (a >= W) ? 0 : (b << a);
            8: r = a ^ b;
            9: r = a & b;
            10: r = a | b;
            default: return {1'b1, {W{1'b0}}};
        endcase
`ifdef ALU_STREAM_SAT_EN
        if (m <= 3) begin
            if (r > maxv) r = maxv;
            if (r < 0) r = 0;
        end
`endif
        r = r & maxv;
        return {1'b0, r[W-1:0]};
    endfunction

    // Presents one operation and waits for its result, counting the cycles
    // after acceptance. During the wait it drives garbage with in_valid high.
    // It then consumes the result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] m,
                         output int lat, output logic [W-1:0] c, output logic e,
                         output int rdyHits);
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        mode_in = m;
        @(posedge clk); #1;
        a_in = W'($urandom);
        b_in = W'($urandom);
        mode_in = 4'($urandom);
        lat = 0;
        rdyHits = 0;
        while (!out_valid && lat < 4 * W) begin
            if (in_ready) rdyHits++;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        c = c_out;
        e = err_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        expCount++;
    endtask

    // Hold reset and check the cleared state, including in_ready low.
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a_in = '0;
        b_in = '0;
        mode_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (c_out !== '0) begin errors++; $display("[TB] FAIL reset_c_out got %0d want 0", c_out); end
        checks++; if (err_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_out got %0b want 0", err_out); end
        checks++; if (op_count !== '0) begin errors++; $display("[TB] FAIL reset_op_count got %0d want 0", op_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %0b want 0", in_ready); end
        rst = 1'b0;
        expCount = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready got %0b want 1", in_ready); end
    endtask

    // Fixed vectors with known answers, including the saturation cases,
    // the illegal mode and the multiply.
    task automatic test_directed();
        int modes[12] = '{0, 1, 2, 4, 5, 6, 7, 0, 1, 12, 9, 3};
        int as[12]    = '{12, 45, 10, 9, 9, 2, 3, 200, 10, 1, 56, 3};
        int bs[12]    = '{34, 10, 44, 1, 1, 32, 3, 100, 20, 1, 78, 7};
`ifdef ALU_STREAM_SAT_EN
        int expC[12]  = '{46, 35, 34, 4, 18, 8, 24, 255, 0, 0, 8, 21};
`else
        int expC[12]  = '{46, 35, 34, 4, 18, 8, 24, 44, 246, 0, 8, 21};
`endif
        int lat;
        int rdy;
        logic [W-1:0] c;
        logic e;
        for (int i = 0; i < 12; i++) begin
            issue(W'(as[i]), W'(bs[i]), 4'(modes[i]), lat, c, e, rdy);
            checks++; if (c !== W'(expC[i])) begin errors++; $display("[TB] FAIL directed_c[%0d] got %0d want %0d", i, c, expC[i]); end
            checks++; if (e !== (modes[i] == 12)) begin errors++; $display("[TB] FAIL directed_err[%0d] got %0b want %0b", i, e, modes[i] == 12); end
            checks++; if (lat !== ((modes[i] == 3) ? W : 0)) begin errors++; $display("[TB] FAIL directed_latency[%0d] got %0d want %0d", i, lat, (modes[i] == 3) ? W : 0); end
            checks++; if (rdy !== 0) begin errors++; $display("[TB] FAIL directed_busy_ready[%0d] got %0d want 0", i, rdy); end
        end
        checks++; if (op_count !== CW'(expCount)) begin errors++; $display("[TB] FAIL directed_op_count got %0d want %0d", op_count, expCount); end
    endtask

    // Random operands and modes checked against the model.
    task automatic test_random();
        int lat;
        int rdy;
        logic [W-1:0] c;
        logic e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int m;
        logic [W:0] exp;
        for (int i = 0; i < 60; i++) begin
            m = $urandom_range(0, 15);
            a = (i % 3 == 0) ? W'($urandom_range(0, 10)) : W'($urandom);
            b = (i % 2 == 0) ? W'($urandom_range(0, 10)) : W'($urandom);
            exp = model(longint'(a), longint'(b), m);
            issue(a, b, 4'(m), lat, c, e, rdy);
            checks++; if ({e, c} !== exp) begin errors++; $display("[TB] FAIL random_result mode %0d a %0d b %0d got err %0b c %0d want err %0b c %0d", m, a, b, e, c, exp[W], exp[W-1:0]); end
            checks++; if (lat !== ((m == 3) ? W : 0)) begin errors++; $display("[TB] FAIL random_latency mode %0d got %0d want %0d", m, lat, (m == 3) ? W : 0); end
        end
        checks++; if (op_count !== CW'(expCount)) begin errors++; $display("[TB] FAIL random_op_count got %0d want %0d", op_count, expCount); end
    endtask

    // A result is held under backpressure. A stream of single-cycle
    // operations then moves one result per edge.
    task automatic test_back_to_back();
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        int qm[$];
        logic [W:0] held;
        logic [W:0] exp;
        int modesOk[10] = '{0, 1, 2, 4, 5, 6, 7, 8, 9, 13};
        for (int i = 0; i < 7; i++) begin
            qa.push_back(W'($urandom));
            qb.push_back(W'($urandom_range(0, 9)));
            qm.push_back(modesOk[$urandom_range(0, 9)]);
        end
        held = model(longint'(qa[0]), longint'(qb[0]), qm[0]);
        in_valid = 1'b1;
        a_in = qa[0];
        b_in = qb[0];
        mode_in = 4'(qm[0]);
        @(posedge clk); #1;
        a_in = qa[1];
        b_in = qb[1];
        mode_in = 4'(qm[1]);
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid[%0d] got %0b want 1", k, out_valid); end
            checks++; if ({err_out, c_out} !== held) begin errors++; $display("[TB] FAIL hold_result[%0d] got %0d want %0d", k, {err_out, c_out}, held); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready[%0d] got %0b want 0", k, in_ready); end
            checks++; if (op_count !== CW'(expCount)) begin errors++; $display("[TB] FAIL hold_op_count[%0d] got %0d want %0d", k, op_count, expCount); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 1; i < 7; i++) begin
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready[%0d] got %0b want 1", i, in_ready); end
            @(posedge clk); #1;
            expCount++;
            exp = model(longint'(qa[i]), longint'(qb[i]), qm[i]);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid[%0d] got %0b want 1", i, out_valid); end
            checks++; if ({err_out, c_out} !== exp) begin errors++; $display("[TB] FAIL b2b_result[%0d] got %0d want %0d", i, {err_out, c_out}, exp); end
            checks++; if (op_count !== CW'(expCount)) begin errors++; $display("[TB] FAIL b2b_op_count[%0d] got %0d want %0d", i, op_count, expCount); end
            if (i < 6) begin
                a_in = qa[i+1];
                b_in = qb[i+1];
                mode_in = 4'(qm[i+1]);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        expCount++;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain_valid got %0b want 0", out_valid); end
        checks++; if (op_count !== CW'(expCount)) begin errors++; $display("[TB] FAIL b2b_drain_op_count got %0d want %0d", op_count, expCount); end
    endtask

    // A reset in the middle of a multiply produces no result. The next
    // multiply completes normally.
    task automatic test_reset_mid_mul();
        int seen = 0;
        int lat;
        int rdy;
        logic [W-1:0] c;
        logic e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0] exp;
        in_valid = 1'b1;
        a_in = W'($urandom);
        b_in = W'($urandom);
        mode_in = 4'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready got %0b want 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        expCount = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 2 * W; k++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL abort_no_result got %0d valid cycles want 0", seen); end
        checks++; if (op_count !== '0) begin errors++; $display("[TB] FAIL abort_op_count got %0d want 0", op_count); end
        a = W'($urandom);
        b = W'($urandom);
        exp = model(longint'(a), longint'(b), 3);
        issue(a, b, 4'd3, lat, c, e, rdy);
        checks++; if ({e, c} !== exp) begin errors++; $display("[TB] FAIL after_abort_result got %0d want %0d", {e, c}, exp); end
        checks++; if (lat !== W) begin errors++; $display("[TB] FAIL after_abort_latency got %0d want %0d", lat, W); end
        checks++; if (op_count !== CW'(1)) begin errors++; $display("[TB] FAIL after_abort_op_count got %0d want 1", op_count); end
    endtask

    // Run the scenarios in order and print the summary.
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
